// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant/done handshake and shared mux data bundle for mux_rr_arbiter
interface mux_rr_arbiter_if #(
   parameter int DATA_W = 2
);
   logic              req_a;
   logic              req_b;
   logic              done_a;
   logic              done_b;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              grant_a;
   logic              grant_b;
   logic              sel;
   logic [DATA_W-1:0] Y;
   logic              y_valid;
   logic              preempt;

   modport master (
      output req_a, req_b, done_a, done_b, A, B,
      input  grant_a, grant_b, sel, Y, y_valid, preempt
   );

   modport slave (
      input  req_a, req_b, done_a, done_b, A, B,
      output grant_a, grant_b, sel, Y, y_valid, preempt
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-requester round-robin arbiter owning a registered 2:1 mux datapath
// ARB_HOLD_LIMIT_EN enables the MAX_HOLD forced-release counter and the preempt pulse.
module mux_rr_arbiter #(
   parameter int DATA_W = 2
`ifdef ARB_HOLD_LIMIT_EN
   , parameter int MAX_HOLD = 8
`endif
) (
   input logic             clk,
   input logic             rst_n,
   mux_rr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t            state, state_nxt;
   logic              last_owner, last_owner_nxt;   // 1 = B owned last
   logic              sel_q, sel_nxt;
   logic [DATA_W-1:0] y_q;
   logic              y_valid_q;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_at_max;
   logic             preempt_q, preempt_nxt;

   assign hold_at_max = (hold_cnt == CNT_W'(MAX_HOLD));
`endif

   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
`ifdef ARB_HOLD_LIMIT_EN
      preempt_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.req_a && bus.req_b)
               state_nxt = last_owner ? OWN_A : OWN_B;
            else if (bus.req_a)
               state_nxt = OWN_A;
            else if (bus.req_b)
               state_nxt = OWN_B;
         end
         OWN_A: begin
            if (bus.done_a || !bus.req_a) begin
               last_owner_nxt = 1'b0;
               state_nxt      = bus.req_b ? OWN_B : IDLE;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_at_max && bus.req_b) begin
               last_owner_nxt = 1'b0;
               state_nxt      = OWN_B;
               preempt_nxt    = 1'b1;
            end
`endif
         end
         OWN_B: begin
            if (bus.done_b || !bus.req_b) begin
               last_owner_nxt = 1'b1;
               state_nxt      = bus.req_a ? OWN_A : IDLE;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_at_max && bus.req_a) begin
               last_owner_nxt = 1'b1;
               state_nxt      = OWN_A;
               preempt_nxt    = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase

      // select tracks the owner and keeps the last owner's path while idle
      sel_nxt = sel_q;
      if (state_nxt == OWN_A)
         sel_nxt = 1'b0;
      else if (state_nxt == OWN_B)
         sel_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         sel_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         sel_q      <= sel_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         case (state)
            OWN_A: begin
               y_q       <= bus.A;
               y_valid_q <= 1'b1;
            end
            OWN_B: begin
               y_q       <= bus.B;
               y_valid_q <= 1'b1;
            end
            default: y_valid_q <= 1'b0;
         endcase
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   // counts owned cycles: 1 on the first grant cycle, saturating at MAX_HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= preempt_nxt;
         if (state_nxt == IDLE)
            hold_cnt <= '0;
         else if (state_nxt != state)
            hold_cnt <= CNT_W'(1);
         else if (!hold_at_max)
            hold_cnt <= hold_cnt + CNT_W'(1);
      end
   end

   assign bus.preempt = preempt_q;
`else
   assign bus.preempt = 1'b0;
`endif

   assign bus.grant_a = (state == OWN_A);
   assign bus.grant_b = (state == OWN_B);
   assign bus.sel     = sel_q;
   assign bus.Y       = y_q;
   assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
   localparam int DATA_W = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [DATA_W-1:0] exp_q[$];

   mux_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();
   mux_rr_arbiter #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: queue expected Y if valid this cycle, then check control outputs after the edge
   task automatic step(input logic ga, input logic gb, input logic s, input logic pe,
                       input logic pv, input logic [DATA_W-1:0] py);
      if (pv) exp_q.push_back(py);
      @(posedge clk); #1;
      check("grant_a", bus.grant_a, ga);
      check("grant_b", bus.grant_b, gb);
      check("sel", bus.sel, s);
      check("preempt", bus.preempt, pe);
      check("y_valid", bus.y_valid, pv);
   endtask

   initial begin : monitor
      logic [DATA_W-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.y_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL y_unexpected: Y=%0h valid with no expected entry at %0t", bus.Y, $time);
            end else begin
               e = exp_q.pop_front();
               check("Y", bus.Y, e);
            end
         end
      end
   end

   initial begin : stimulus
      logic own_b;
      logic [DATA_W-1:0] d;
      rst_n = 1'b0;
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      bus.done_a = 1'b0; bus.done_b = 1'b0;
      bus.A = '0; bus.B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant_a", bus.grant_a, 0);
      check("rst_grant_b", bus.grant_b, 0);
      check("rst_sel", bus.sel, 0);
      check("rst_Y", bus.Y, 0);
      check("rst_y_valid", bus.y_valid, 0);
      check("rst_preempt", bus.preempt, 0);
      rst_n = 1'b1;

      // single request, done pulse
      bus.req_a = 1'b1; bus.A = 2'b10;
      step(1, 0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 1, 2'b10);
      bus.done_a = 1'b1;
      step(0, 0, 0, 0, 1, 2'b10);
      bus.done_a = 1'b0; bus.req_a = 1'b0;
      step(0, 0, 0, 0, 0, '0);
      check("y_hold_after_done", bus.Y, 2'b10);

      // handoff A->B with data switch one edge after sel
      bus.A = 2'b01; bus.B = 2'b11; bus.req_a = 1'b1;
      step(1, 0, 0, 0, 0, '0);
      bus.req_b = 1'b1;
      step(1, 0, 0, 0, 1, 2'b01);
      bus.done_a = 1'b1;
      step(0, 1, 1, 0, 1, 2'b01);
      bus.done_a = 1'b0; bus.req_a = 1'b0;
      step(0, 1, 1, 0, 1, 2'b11);
      bus.req_b = 1'b0;
      step(0, 0, 1, 0, 1, 2'b11);
      step(0, 0, 1, 0, 0, '0);

      // round robin, both held, done every 3rd owned cycle
      bus.A = 2'b10; bus.B = 2'b01;
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      step(1, 0, 0, 0, 0, '0);
      for (int n = 0; n < 4; n++) begin
         own_b = n[0];
         d = own_b ? bus.B : bus.A;
         repeat (2) step(!own_b, own_b, own_b, 0, 1, d);
         if (own_b) bus.done_b = 1'b1;
         else       bus.done_a = 1'b1;
         step(own_b, !own_b, !own_b, 0, 1, d);
         bus.done_a = 1'b0; bus.done_b = 1'b0;
      end
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      step(0, 0, 0, 0, 1, 2'b10);
      step(0, 0, 0, 0, 0, '0);

      // stray done_b while A owns, then req_a drop to idle
      bus.A = 2'b11; bus.req_a = 1'b1;
      step(1, 0, 0, 0, 0, '0);
      bus.done_b = 1'b1;
      repeat (2) step(1, 0, 0, 0, 1, 2'b11);
      bus.done_b = 1'b0; bus.req_a = 1'b0;
      step(0, 0, 0, 0, 1, 2'b11);
      bus.A = 2'b00;
      step(0, 0, 0, 0, 0, '0);
      check("y_hold_idle", bus.Y, 2'b11);

      // both request after A owned last -> B wins
      bus.B = 2'b10; bus.req_a = 1'b1; bus.req_b = 1'b1;
      step(0, 1, 1, 0, 0, '0);
      step(0, 1, 1, 0, 1, 2'b10);

      // reset mid-ownership of B
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant_b", bus.grant_b, 0);
      check("mid_rst_grant_a", bus.grant_a, 0);
      check("mid_rst_y_valid", bus.y_valid, 0);
      check("mid_rst_Y", bus.Y, 0);
      check("mid_rst_sel", bus.sel, 0);
      check("mid_rst_preempt", bus.preempt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.A = 2'b01;
      step(1, 0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 1, 2'b01);
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      step(0, 0, 0, 0, 1, 2'b01);
      step(0, 0, 0, 0, 0, '0);

`ifdef ARB_HOLD_LIMIT_EN
      // forced release after MAX_HOLD=8 owned cycles, then uncontested hold
      bus.A = 2'b10; bus.B = 2'b11; bus.req_a = 1'b1;
      step(1, 0, 0, 0, 0, '0);
      bus.req_b = 1'b1;
      repeat (7) step(1, 0, 0, 0, 1, 2'b10);
      step(0, 1, 1, 1, 1, 2'b10);
      bus.req_b = 1'b0;
      step(1, 0, 0, 0, 1, 2'b11);
      repeat (12) step(1, 0, 0, 0, 1, 2'b10);
      bus.req_a = 1'b0;
      step(0, 0, 0, 0, 1, 2'b10);
      step(0, 0, 0, 0, 0, '0);
`endif

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
